// File: rtl/tick_generator.sv
// tick_generator: multi-channel, runtime-programmable clock-enable generator.
// Each channel emits a registered single-cycle tick once per programmed period
// (D = max(divider, 1) enabled cycles). Dividers are rewritten through a
// valid/ready config port, either immediately (restart) or at the next period
// end (shadowed, flagged on pending).
//
// Optional feature: define TICK_FRAC_EN to add a per-channel fractional
// accumulator (cfg_frac port) that stretches some periods by one cycle so the
// average period becomes D + frac / 2^FRAC_WIDTH.
//
// Ports:
//   clock, reset    system clock, asynchronous active-high reset
//   enable          per-channel run enable (counter holds when low)
//   sync            pulse: phase-aligns all channels (counters to 0)
//   cfg_valid/ready config handshake; ready = !pending[cfg_channel]
//   cfg_channel     target channel (out-of-range writes accepted and dropped)
//   cfg_divider     new period in cycles (0 and 1 both tick every cycle)
//   cfg_restart     1: apply now and clear counter, 0: apply at period end
//   cfg_frac        fractional period part (TICK_FRAC_EN only)
//   tick            registered single-cycle tick per channel
//   pending         shadow divider waiting for period end
module tick_generator #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned RESET_DIV  = 25,
    parameter int unsigned FRAC_WIDTH = 8,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   enable,
    input  logic                  sync,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_channel,
    input  logic [DIV_WIDTH-1:0]  cfg_divider,
    input  logic                  cfg_restart,
`ifdef TICK_FRAC_EN
    input  logic [FRAC_WIDTH-1:0] cfg_frac,
`endif
    output logic [CHANNELS-1:0]   tick,
    output logic [CHANNELS-1:0]   pending
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be at least 1");
    end
    if (FRAC_WIDTH < 1) begin : g_bad_frac
        $error("FRAC_WIDTH must be at least 1");
    end
    if (DIV_WIDTH < 32 && (RESET_DIV >> DIV_WIDTH) != 0) begin : g_bad_reset_div
        $error("RESET_DIV does not fit DIV_WIDTH");
    end

    logic [DIV_WIDTH-1:0] count_q      [CHANNELS];
    logic [DIV_WIDTH-1:0] count_d      [CHANNELS];
    logic [DIV_WIDTH-1:0] active_div_q [CHANNELS];
    logic [DIV_WIDTH-1:0] active_div_d [CHANNELS];
    logic [DIV_WIDTH-1:0] shadow_div_q [CHANNELS];
    logic [DIV_WIDTH-1:0] shadow_div_d [CHANNELS];
    logic [CHANNELS-1:0]  pending_q, pending_d;
    logic [CHANNELS-1:0]  tick_q, tick_d;
    logic [CHANNELS-1:0]  wr_hit;
    logic [CHANNELS-1:0]  terminal;
    logic                 cfg_fire;

`ifdef TICK_FRAC_EN
    logic [FRAC_WIDTH-1:0] active_frac_q [CHANNELS];
    logic [FRAC_WIDTH-1:0] active_frac_d [CHANNELS];
    logic [FRAC_WIDTH-1:0] shadow_frac_q [CHANNELS];
    logic [FRAC_WIDTH-1:0] shadow_frac_d [CHANNELS];
    logic [FRAC_WIDTH-1:0] acc_q         [CHANNELS];
    logic [FRAC_WIDTH-1:0] acc_d         [CHANNELS];
    logic [FRAC_WIDTH:0]   frac_sum      [CHANNELS];
    logic [CHANNELS-1:0]   ext_q, ext_d;
`endif

    // Writes to a channel that does not exist are always accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        if (32'(cfg_channel) < CHANNELS) begin
            cfg_ready = !pending_q[cfg_channel];
        end
    end

    assign cfg_fire = cfg_valid && cfg_ready;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            logic [DIV_WIDTH-1:0] limit;
            wr_hit[i] = cfg_fire && (32'(cfg_channel) == i);
            limit = (active_div_q[i] == '0) ? '0 : active_div_q[i] - DIV_WIDTH'(1);
`ifdef TICK_FRAC_EN
            limit       = limit + DIV_WIDTH'(ext_q[i]);
            frac_sum[i] = {1'b0, acc_q[i]} + {1'b0, active_frac_q[i]};
`endif
            terminal[i] = (count_q[i] == limit);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]      = count_q[i];
            active_div_d[i] = active_div_q[i];
            shadow_div_d[i] = shadow_div_q[i];
            pending_d[i]    = pending_q[i];
            tick_d[i]       = 1'b0;
`ifdef TICK_FRAC_EN
            active_frac_d[i] = active_frac_q[i];
            shadow_frac_d[i] = shadow_frac_q[i];
            acc_d[i]         = acc_q[i];
            ext_d[i]         = ext_q[i];
`endif
            // A shadowed write is only accepted while pending is clear, so it
            // can never collide with the period-end application below.
            if (wr_hit[i] && !cfg_restart) begin
                shadow_div_d[i] = cfg_divider;
                pending_d[i]    = 1'b1;
`ifdef TICK_FRAC_EN
                shadow_frac_d[i] = cfg_frac;
`endif
            end
            if (wr_hit[i] && cfg_restart) begin
                active_div_d[i] = cfg_divider;
`ifdef TICK_FRAC_EN
                active_frac_d[i] = cfg_frac;
`endif
            end

            if (sync || (wr_hit[i] && cfg_restart)) begin
                count_d[i] = '0;
`ifdef TICK_FRAC_EN
                acc_d[i] = '0;
                ext_d[i] = 1'b0;
`endif
            end else if (!enable[i]) begin
                // hold
            end else if (terminal[i]) begin
                tick_d[i]  = 1'b1;
                count_d[i] = '0;
`ifdef TICK_FRAC_EN
                acc_d[i] = frac_sum[i][FRAC_WIDTH-1:0];
                ext_d[i] = frac_sum[i][FRAC_WIDTH];
`endif
                if (pending_q[i]) begin
                    active_div_d[i] = shadow_div_q[i];
                    pending_d[i]    = 1'b0;
`ifdef TICK_FRAC_EN
                    active_frac_d[i] = shadow_frac_q[i];
`endif
                end
            end else begin
                count_d[i] = count_q[i] + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]      <= '0;
                active_div_q[i] <= DIV_WIDTH'(RESET_DIV);
                shadow_div_q[i] <= DIV_WIDTH'(RESET_DIV);
`ifdef TICK_FRAC_EN
                active_frac_q[i] <= '0;
                shadow_frac_q[i] <= '0;
                acc_q[i]         <= '0;
`endif
            end
            pending_q <= '0;
            tick_q    <= '0;
`ifdef TICK_FRAC_EN
            ext_q <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]      <= count_d[i];
                active_div_q[i] <= active_div_d[i];
                shadow_div_q[i] <= shadow_div_d[i];
`ifdef TICK_FRAC_EN
                active_frac_q[i] <= active_frac_d[i];
                shadow_frac_q[i] <= shadow_frac_d[i];
                acc_q[i]         <= acc_d[i];
`endif
            end
            pending_q <= pending_d;
            tick_q    <= tick_d;
`ifdef TICK_FRAC_EN
            ext_q <= ext_d;
`endif
        end
    end

    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator (default build). The driver issues one stimulus
// vector per cycle and pushes the reference model's expected {tick, pending}
// into a queue; a monitor pops and compares on each falling edge.
// The model tracks "enabled cycles left until the next tick" per channel.
module tb_tick_generator;

    localparam int CH = 4;
    localparam int RD = 25;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_channel;
    logic [15:0] cfg_divider;
    logic        cfg_restart;
    logic [3:0]  tick;
    logic [3:0]  pending;

    tick_generator #(
        .CHANNELS   (CH),
        .DIV_WIDTH  (16),
        .RESET_DIV  (RD),
        .FRAC_WIDTH (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sync        (sync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_divider (cfg_divider),
        .cfg_restart (cfg_restart),
        .tick        (tick),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int act  [CH];
    int shd  [CH];
    int left [CH];
    bit pend [CH];

    logic [7:0] exp_q[$];

    function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            act[i]  = RD;
            shd[i]  = RD;
            left[i] = RD;
            pend[i] = 1'b0;
        end
    endfunction

    function automatic int period(int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic step(input logic [3:0] en, input bit sy, input bit v, input int ch,
                        input int div, input bit rs);
        bit         rdy;
        bit         acc;
        logic [3:0] et;
        logic [3:0] ep;
        enable      = en;
        sync        = sy;
        cfg_valid   = v;
        cfg_channel = 2'(ch);
        cfg_divider = 16'(div);
        cfg_restart = rs;
        rdy = !pend[ch];
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(rdy));
        @(posedge clock);
        for (int i = 0; i < CH; i++) begin
            acc   = v && rdy && (ch == i);
            et[i] = 1'b0;
            if (acc && rs) act[i] = div;
            if (sy || (acc && rs)) begin
                left[i] = period(act[i]);
            end else if (en[i]) begin
                left[i]--;
                if (left[i] == 0) begin
                    et[i] = 1'b1;
                    if (pend[i]) begin
                        act[i]  = shd[i];
                        pend[i] = 1'b0;
                    end
                    left[i] = period(act[i]);
                end
            end
            if (acc && !rs) begin
                shd[i]  = div;
                pend[i] = 1'b1;
            end
            ep[i] = pend[i];
        end
        exp_q.push_back({et, ep});
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'hF, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: compare every registered output against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick", 32'(tick), 32'(e[7:4]));
                check("pending", 32'(pending), 32'(e[3:0]));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = '0;
        sync        = 1'b0;
        cfg_valid   = 1'b0;
        cfg_channel = '0;
        cfg_divider = '0;
        cfg_restart = 1'b0;
        model_reset();
        #2;
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        #10;
        reset = 1'b0;

        // Reset divider: aligned ticks on every channel after edges 25, 50, 75.
        idle(80);

        // Channel 1 restarted to period 4.
        step(4'hF, 1'b0, 1'b1, 1, 4, 1'b1);
        idle(20);

        // Channel 2 shadowed write, then a second write offered until accepted.
        step(4'hF, 1'b0, 1'b1, 2, 10, 1'b0);
        repeat (30) step(4'hF, 1'b0, 1'b1, 2, 6, 1'b0);
        idle(30);

        // Channel 3 period 8, disabled for 7 cycles mid-period.
        step(4'hF, 1'b0, 1'b1, 3, 8, 1'b1);
        idle(3);
        repeat (7) step(4'h7, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(20);

        // Dividers 0 and 1 tick every cycle; sync suppresses a terminal tick.
        step(4'hF, 1'b0, 1'b1, 0, 0, 1'b1);
        step(4'hF, 1'b0, 1'b1, 1, 1, 1'b1);
        idle(5);
        step(4'hF, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(10);
        step(4'hF, 1'b1, 1'b1, 2, 3, 1'b1);
        idle(10);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            step(en, $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                 1'($urandom));
        end
        idle(30);

        // Asynchronous reset with ticks in flight and an update pending.
        step(4'hF, 1'b0, 1'b1, 0, 1, 1'b1);
        step(4'hF, 1'b0, 1'b1, 3, 20, 1'b1);
        idle(2);
        step(4'hF, 1'b0, 1'b1, 3, 5, 1'b0);
        idle(2);
        #6;
        reset = 1'b1;
        #1;
        check("async_reset_tick", 32'(tick), 32'h0);
        check("async_reset_pending", 32'(pending), 32'h0);
        reset = 1'b0;
        model_reset();
        idle(60);

        #10;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
